py_seq: RTL and testbench

- Payload sequencer for the payload bit-processing datapath (CRC16, whitening, FEC 2/3).
- On a start pulse it generates every timing strobe that datapath consumes: start pulses, data/CRC/whole-payload windows, daten for FEC 2/3 data/parity gating, the FEC block end and the payload end.
- It sits between the packet-level controller, which supplies length and mode, and the payload datapath, paced by the 1 MHz bit tick p_1us.

---
 rtl/py_seq_pkg.sv | 25 ++
 rtl/py_seq_if.sv | 42 ++++
 rtl/py_fecpos_cnt.sv | 29 ++
 rtl/py_seq.sv | 146 ++++++++++++++
 tb/tb_py_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/py_seq_pkg.sv
// Shared types and constants for the payload sequencer.
package py_seq_pkg;

  localparam int unsigned LENW    = 12;
  localparam int unsigned CRCBITS = 16;
  localparam int unsigned FECDAT  = 10;
  localparam int unsigned FECBLK  = 15;
  localparam int unsigned FECPOSW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_TAIL = 2'd3
  } py_state_e;

  // Mode and length captured at payload start
  typedef struct packed {
    logic            pk_encode;
    logic            fec32encode;
    logic            crcen;
    logic [LENW-1:0] bitlen;
  } py_cfg_t;

endpackage

// File: rtl/py_seq_if.sv
// Controller/datapath side signals of the payload sequencer.
interface py_seq_if;
  import py_seq_pkg::*;

  logic            p_1us;
  logic            start_p;
  logic            abort_p;
  logic            pk_encode;
  logic            fec32encode;
  logic            crcen;
  logic [LENW-1:0] py_bitlen;

  logic            busy;
  logic            py_st_p;
  logic            dec_py_st_p;
  logic            py_datvalid_p;
  logic            daten;
  logic            py_daten;
  logic            py_datperiod;
  logic            py_crc16period;
  logic            py_period;
  logic            dec_py_period;
  logic            fec32bk_endp;
  logic            py_endp;
  logic            dec_py_endp;
  logic [1:0]      dec_py_endp_d1;

  modport master (
    output p_1us, start_p, abort_p, pk_encode, fec32encode, crcen, py_bitlen,
    input  busy, py_st_p, dec_py_st_p, py_datvalid_p, daten, py_daten,
           py_datperiod, py_crc16period, py_period, dec_py_period,
           fec32bk_endp, py_endp, dec_py_endp, dec_py_endp_d1
  );

  modport slave (
    input  p_1us, start_p, abort_p, pk_encode, fec32encode, crcen, py_bitlen,
    output busy, py_st_p, dec_py_st_p, py_datvalid_p, daten, py_daten,
           py_datperiod, py_crc16period, py_period, dec_py_period,
           fec32bk_endp, py_endp, dec_py_endp, dec_py_endp_d1
  );

endinterface

// File: rtl/py_fecpos_cnt.sv
// FEC 2/3 block position counter (0..FECBLK-1) with block-end decode.
module py_fecpos_cnt
  import py_seq_pkg::*;
(
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               clr,
  input  logic               adv,
  output logic [FECPOSW-1:0] fecpos,
  output logic               blk_end
);

  logic last_c;

  assign last_c  = (fecpos == FECPOSW'(FECBLK - 1));
  assign blk_end = adv & last_c;

  // Clear has priority so an abort on a tick still leaves the counter at 0
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      fecpos <= '0;
    end else if (clr) begin
      fecpos <= '0;
    end else if (adv) begin
      fecpos <= last_c ? '0 : fecpos + FECPOSW'(1);
    end
  end

endmodule

// File: rtl/py_seq.sv
// Payload sequencer: generates data/CRC/FEC timing strobes for the payload
// bit datapath, one air bit per p_1us tick.
module py_seq
  import py_seq_pkg::*;
(
  input  logic    clk_6M,
  input  logic    rstz,
  py_seq_if.slave sif
);

  py_state_e          state_q, state_d;
  py_cfg_t            cfg_q, cfg_d;
  logic [LENW-1:0]    infocnt_q, infocnt_d;
  logic               py_st_q, py_st_d;
  logic               dec_st_q, dec_st_d;
  logic [1:0]         endp_sr_q, endp_sr_d;
  logic [FECPOSW-1:0] fecpos;
  logic               busy_c, tick_c, daten_c, start_ok_c;
  logic               last_info_c, end_c, fec_adv_c, fec_clr_c, blk_end_c;

  assign busy_c     = (state_q != ST_IDLE);
  assign tick_c     = sif.p_1us & busy_c;
  assign daten_c    = busy_c & (~cfg_q.fec32encode | (fecpos < FECPOSW'(FECDAT)));
  assign start_ok_c = (state_q == ST_IDLE) & sif.start_p & ~sif.abort_p &
                      ((sif.py_bitlen != '0) | sif.crcen);
  assign fec_adv_c  = tick_c & cfg_q.fec32encode;
  assign fec_clr_c  = sif.abort_p | start_ok_c;

  py_fecpos_cnt u_fecpos (
    .clk_6M  (clk_6M),
    .rstz    (rstz),
    .clr     (fec_clr_c),
    .adv     (fec_adv_c),
    .fecpos  (fecpos),
    .blk_end (blk_end_c)
  );

  // Next-state, info-bit accounting and end detection
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    infocnt_d   = infocnt_q;
    py_st_d     = 1'b0;
    dec_st_d    = 1'b0;
    last_info_c = 1'b0;
    end_c       = 1'b0;

    if (sif.abort_p) begin
      state_d   = ST_IDLE;
      infocnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok_c) begin
            cfg_d.pk_encode   = sif.pk_encode;
            cfg_d.fec32encode = sif.fec32encode;
            cfg_d.crcen       = sif.crcen;
            cfg_d.bitlen      = sif.py_bitlen;
            infocnt_d         = '0;
            py_st_d           = sif.pk_encode;
            dec_st_d          = ~sif.pk_encode;
            state_d           = (sif.py_bitlen == '0) ? ST_CRC : ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_c && daten_c) begin
            infocnt_d = infocnt_q + LENW'(1);
            if (infocnt_q == cfg_q.bitlen - LENW'(1)) begin
              if (cfg_q.crcen) begin
                state_d   = ST_CRC;
                infocnt_d = '0;
              end else begin
                last_info_c = 1'b1;
              end
            end
          end
        end
        ST_CRC: begin
          if (tick_c && daten_c) begin
            infocnt_d = infocnt_q + LENW'(1);
            if (infocnt_q == LENW'(CRCBITS - 1)) last_info_c = 1'b1;
          end
        end
        ST_TAIL: begin
          if (tick_c) begin
            if (daten_c) infocnt_d = infocnt_q + LENW'(1);
            if (fecpos == FECPOSW'(FECBLK - 1)) begin
              end_c     = 1'b1;
              state_d   = ST_IDLE;
              infocnt_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Without FEC the last info bit is the last air bit; with FEC the
      // block is finished off with pad and parity bits
      if (last_info_c) begin
        if (cfg_q.fec32encode) begin
          state_d = ST_TAIL;
        end else begin
          end_c     = 1'b1;
          state_d   = ST_IDLE;
          infocnt_d = '0;
        end
      end
    end

    endp_sr_d = sif.abort_p ? 2'b00 : {endp_sr_q[0], end_c};
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      infocnt_q <= '0;
      py_st_q   <= 1'b0;
      dec_st_q  <= 1'b0;
      endp_sr_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      infocnt_q <= infocnt_d;
      py_st_q   <= py_st_d;
      dec_st_q  <= dec_st_d;
      endp_sr_q <= endp_sr_d;
    end
  end

  assign sif.busy           = busy_c;
  assign sif.py_st_p        = py_st_q;
  assign sif.dec_py_st_p    = dec_st_q;
  assign sif.py_datvalid_p  = tick_c;
  assign sif.daten          = daten_c;
  assign sif.py_daten       = daten_c;
  assign sif.py_datperiod   = (state_q == ST_DATA);
  assign sif.py_crc16period = (state_q == ST_CRC);
  assign sif.py_period      = busy_c & cfg_q.pk_encode;
  assign sif.dec_py_period  = busy_c & ~cfg_q.pk_encode;
  assign sif.fec32bk_endp   = blk_end_c;
  assign sif.py_endp        = end_c & cfg_q.pk_encode;
  assign sif.dec_py_endp    = end_c & ~cfg_q.pk_encode;
  assign sif.dec_py_endp_d1 = endp_sr_q;

endmodule

// File: tb/tb_py_seq.sv
// Randomized self-checking bench for py_seq against an air-bit position model.
module tb_py_seq;
  import py_seq_pkg::*;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  always #5 clk_6M = ~clk_6M;

  py_seq_if sif ();

  py_seq u_dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .sif    (sif)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model state: active transaction and end-pulse history
  bit         m_enc, m_fec, m_crc;
  int         m_len, m_total, m_n;
  logic [1:0] h = 2'b00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // {busy, st, dec_st, datvalid, daten, py_daten, datper, crcper, per, dec_per, bk_end, endp, dec_endp, d1[1:0]}
  function automatic logic [14:0] act_vec();
    return {sif.busy, sif.py_st_p, sif.dec_py_st_p, sif.py_datvalid_p, sif.daten,
            sif.py_daten, sif.py_datperiod, sif.py_crc16period, sif.py_period,
            sif.dec_py_period, sif.fec32bk_endp, sif.py_endp, sif.dec_py_endp,
            sif.dec_py_endp_d1};
  endfunction

  function automatic logic [14:0] idle_vec();
    logic [14:0] v;
    v = '0;
    v[1:0] = h;
    return v;
  endfunction

  // Expected outputs when j air bits have already gone out
  function automatic logic [14:0] exp_vec(int j, bit tk, bit st);
    logic [14:0] v;
    int p, idx, wt;
    bit par;
    v = idle_vec();
    if (j >= m_n) return v;
    if (m_fec) begin
      p   = j % 15;
      par = (p >= 10);
      idx = par ? (j / 15 + 1) * 10 : (j / 15) * 10 + p;
    end else begin
      p   = 0;
      par = 1'b0;
      idx = j;
    end
    wt = (idx < m_len) ? 1 : ((idx < m_total) ? 2 : 0);
    v[14] = 1'b1;
    v[13] = st && m_enc;
    v[12] = st && !m_enc;
    v[11] = tk;
    v[10] = !par;
    v[9]  = !par;
    v[8]  = (wt == 1);
    v[7]  = (wt == 2);
    v[6]  = m_enc;
    v[5]  = !m_enc;
    v[4]  = tk && m_fec && (p == 14);
    v[3]  = tk && (j == m_n - 1) && m_enc;
    v[2]  = tk && (j == m_n - 1) && !m_enc;
    return v;
  endfunction

  task automatic cyc(input bit tk, input string tag, input logic [14:0] ev);
    sif.p_1us = tk;
    @(negedge clk_6M);
    chk(tag, 32'(act_vec()), 32'(ev));
    h = {h[0], ev[3] | ev[2]};
    @(posedge clk_6M);
    #1;
    sif.p_1us   = 1'b0;
    sif.start_p = 1'b0;
    sif.abort_p = 1'b0;
  endtask

  task automatic run_txn(input bit enc, input bit fec, input bit crc, input int len,
                         input int max_gap, input int cut_at, input bit cut_rst);
    int j, gap;
    bit st;
    m_enc   = enc;
    m_fec   = fec;
    m_crc   = crc;
    m_len   = len;
    m_total = len + (crc ? 16 : 0);
    m_n     = fec ? ((m_total + 9) / 10) * 15 : m_total;
    sif.start_p     = 1'b1;
    sif.pk_encode   = enc;
    sif.fec32encode = fec;
    sif.crcen       = crc;
    sif.py_bitlen   = LENW'(len);
    cyc(1'b0, "start", idle_vec());
    sif.pk_encode   = 1'($urandom);
    sif.fec32encode = 1'($urandom);
    sif.crcen       = 1'($urandom);
    sif.py_bitlen   = LENW'($urandom);
    j  = 0;
    st = 1'b1;
    while (j < m_n) begin
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(5, 0) == 0) begin
          sif.start_p   = 1'b1;
          sif.crcen     = 1'b1;
          sif.py_bitlen = LENW'($urandom);
        end
        cyc(1'b0, "gap", exp_vec(j, 1'b0, st));
        st = 1'b0;
      end
      if (j == cut_at) begin
        if (cut_rst) begin
          rstz = 1'b0;
          #1;
          chk("rst_mid", 32'(act_vec()), 32'd0);
          @(posedge clk_6M);
          #1;
          rstz = 1'b1;
          h = 2'b00;
        end else begin
          sif.abort_p = 1'b1;
          cyc(1'b0, "abort", exp_vec(j, 1'b0, st));
          h = 2'b00;
        end
        cyc(1'b0, "post_cut", idle_vec());
        cyc(1'b0, "post_cut2", idle_vec());
        return;
      end
      cyc(1'b1, "tick", exp_vec(j, 1'b1, st));
      st = 1'b0;
      j++;
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, "after_end", idle_vec());
  endtask

  initial begin
    sif.p_1us       = 1'b0;
    sif.start_p     = 1'b0;
    sif.abort_p     = 1'b0;
    sif.pk_encode   = 1'b0;
    sif.fec32encode = 1'b0;
    sif.crcen       = 1'b0;
    sif.py_bitlen   = '0;
    #12;
    chk("reset", 32'(act_vec()), 32'd0);
    @(posedge clk_6M);
    #1;
    rstz = 1'b1;
    cyc(1'b0, "idle0", idle_vec());

    // Directed cases
    run_txn(1'b1, 1'b0, 1'b1, 8,   1, -1, 1'b0);
    run_txn(1'b1, 1'b1, 1'b1, 8,   1, -1, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 10,  2, -1, 1'b0);
    run_txn(1'b1, 1'b0, 1'b1, 0,   1, -1, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 9,   1, -1, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 1,   0, -1, 1'b0);

    // Zero-length without CRC is ignored
    sif.start_p = 1'b1; sif.pk_encode = 1'b1; sif.crcen = 1'b0; sif.py_bitlen = '0;
    cyc(1'b0, "nolen_start", idle_vec());
    cyc(1'b1, "nolen_1", idle_vec());
    cyc(1'b0, "nolen_2", idle_vec());

    // Abort beats a simultaneous start
    sif.start_p = 1'b1; sif.abort_p = 1'b1; sif.pk_encode = 1'b0;
    sif.crcen = 1'b1; sif.py_bitlen = LENW'(20);
    cyc(1'b0, "abst_start", idle_vec());
    cyc(1'b0, "abst_1", idle_vec());

    // Abort mid-payload, then a clean full sequence
    run_txn(1'b0, 1'b1, 1'b1, 100, 1, 5,  1'b0);
    run_txn(1'b1, 1'b1, 1'b1, 17,  1, -1, 1'b0);

    // Reset mid-payload, then a clean full sequence
    run_txn(1'b1, 1'b1, 1'b0, 60,  1, 20, 1'b1);
    run_txn(1'b0, 1'b0, 1'b1, 33,  1, -1, 1'b0);

    // Longest payload
    run_txn(1'b1, 1'b1, 1'b1, 4095, 0, -1, 1'b0);

    // Random mix
    for (int t = 0; t < 30; t++) begin
      bit r_enc, r_fec, r_crc;
      int r_len;
      r_enc = 1'($urandom);
      r_fec = 1'($urandom);
      r_crc = 1'($urandom);
      r_len = $urandom_range(300, 0);
      if (r_len == 0) r_crc = 1'b1;
      run_txn(r_enc, r_fec, r_crc, r_len, 2, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
